gcd_engine: RTL

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_pkg.sv | 15 +
 rtl/gcd_divider.sv | 68 ++++++
 rtl/gcd_engine.sv | 127 ++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// gcd_engine shared types: controller states and mode encodings.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIVIDE,
        UPDATE,
        FINISH
    } state_t;

    localparam logic MODE_GCD = 1'b0;
    localparam logic MODE_INV = 1'b1;

endpackage

// File: rtl/gcd_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle.
// The first bit is resolved on the go edge, so results settle WIDTH cycles later.
module gcd_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] src_quo;
    logic [WIDTH-1:0] src_rem;
    logic [WIDTH-1:0] src_dvs;
    logic [WIDTH-1:0] nxt_quo;
    logic [WIDTH-1:0] nxt_rem;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        src_quo = go ? dividend : quo_q;
        src_rem = go ? '0 : rem_q;
        src_dvs = go ? divisor : dvs_q;
        shifted = {src_rem, src_quo[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, src_dvs};
        if (diff[WIDTH+1]) begin
            nxt_rem = shifted[WIDTH-1:0];
            nxt_quo = {src_quo[WIDTH-2:0], 1'b0};
        end else begin
            nxt_rem = diff[WIDTH-1:0];
            nxt_quo = {src_quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (go) begin
            quo_q <= nxt_quo;
            rem_q <= nxt_rem;
            dvs_q <= divisor;
            cnt_q <= CW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            quo_q <= nxt_quo;
            rem_q <= nxt_rem;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign ready     = (cnt_q == '0);

endmodule

// File: rtl/gcd_engine.sv
// Euclidean gcd engine with optional modular inverse of a mod b.
// Results are registered on the CHECK->FINISH edge so they are valid with done.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd,
    output logic [WIDTH-1:0] inv,
    output logic             inv_ok
);

    state_t state_q, state_n;

    logic [WIDTH-1:0]        r0_q, r1_q, b_q;
    logic signed [WIDTH:0]   s0_q, s1_q;
    logic                    mode_q;
    logic [WIDTH-1:0]        gcd_q, inv_q;
    logic                    inv_ok_q;

    logic                    div_go;
    logic                    div_ready;
    logic [WIDTH-1:0]        quo, rem;
    logic signed [2*WIDTH+1:0] prod;
    logic signed [WIDTH:0]   s1_next;
    logic [WIDTH-1:0]        inv_map;
    logic                    fin_ok;
    logic                    r1_zero;

    gcd_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (div_go),
        .dividend  (r0_q),
        .divisor   (r1_q),
        .quotient  (quo),
        .remainder (rem),
        .ready     (div_ready)
    );

    assign r1_zero = (r1_q == '0);

    always_comb begin
        state_n = state_q;
        div_go  = 1'b0;
        unique case (state_q)
            IDLE:   if (start) state_n = CHECK;
            CHECK: begin
                if (r1_zero) begin
                    state_n = FINISH;
                end else begin
                    div_go  = 1'b1;
                    state_n = DIVIDE;
                end
            end
            DIVIDE: if (div_ready) state_n = UPDATE;
            UPDATE: state_n = CHECK;
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // q*s1 kept at full width; |s| <= b keeps the truncated result exact
    always_comb begin
        prod    = $signed({1'b0, quo}) * s1_q;
        s1_next = s0_q - $signed(prod[WIDTH:0]);
        inv_map = s0_q[WIDTH] ? s0_q[WIDTH-1:0] + b_q : s0_q[WIDTH-1:0];
        fin_ok  = (mode_q == MODE_INV) && (r0_q == WIDTH'(1)) && (b_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_q     <= '0;
            r1_q     <= '0;
            b_q      <= '0;
            s0_q     <= '0;
            s1_q     <= '0;
            mode_q   <= MODE_GCD;
            gcd_q    <= '0;
            inv_q    <= '0;
            inv_ok_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                r0_q   <= a;
                r1_q   <= b;
                b_q    <= b;
                s0_q   <= {{WIDTH{1'b0}}, 1'b1};
                s1_q   <= '0;
                mode_q <= mode;
            end
            if (state_q == UPDATE) begin
                r0_q <= r1_q;
                r1_q <= rem;
                if (mode_q == MODE_INV) begin
                    s0_q <= s1_q;
                    s1_q <= s1_next;
                end
            end
            if (state_q == CHECK && r1_zero) begin
                gcd_q    <= r0_q;
                inv_ok_q <= fin_ok;
                inv_q    <= fin_ok ? inv_map : '0;
            end
        end
    end

    assign busy   = (state_q == CHECK) || (state_q == DIVIDE) ||
                    (state_q == UPDATE);
    assign done   = (state_q == FINISH);
    assign gcd    = gcd_q;
    assign inv    = inv_q;
    assign inv_ok = inv_ok_q;

endmodule
